// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Load/store controller for word-wide memory; sub-word stores as RMW.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic [31:0]       mem_data_out
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_RD     = 3'd1;
  localparam logic [2:0] c_RMW_RD = 3'd2;
  localparam logic [2:0] c_WR     = 3'd3;
  localparam logic [2:0] c_RESP   = 3'd4;

  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;
  localparam logic [1:0] c_SZ_W = 2'b10;

  logic [2:0]        r_state;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_buf;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_bad;
  logic [31:0]       w_shifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_accept = req_valid && req_ready;
  assign w_bad    = (req_size == 2'b11) ||
                    (req_size == c_SZ_H && req_addr[0]) ||
                    (req_size == c_SZ_W && req_addr[1:0] != 2'b00);

  assign w_shifted = mem_data_out >> {r_addr[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_addr[1] ? mem_data_out[31:16] : mem_data_out[15:0];

  always_comb begin
    w_load = mem_data_out;
    case (r_size)
      c_SZ_B:  w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      c_SZ_H:  w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = mem_data_out;
    endcase
  end

  // Store data sits right-justified in the buffer until the old word is merged.
  always_comb begin
    w_merge = mem_data_out;
    if (r_size == c_SZ_B) begin
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_buf[7:0];
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_buf[15:0];
    end else begin
      w_merge[15:0] = r_buf[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_buf      <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_buf      <= req_wdata;
            r_rdata    <= 32'h0;
            r_err      <= w_bad;
            if (w_bad)                  r_state <= c_RESP;
            else if (!req_wr)           r_state <= c_RD;
            else if (req_size == c_SZ_W) r_state <= c_WR;
            else                        r_state <= c_RMW_RD;
          end
        end
        c_RD: begin
          r_rdata <= w_load;
          r_state <= c_RESP;
        end
        c_RMW_RD: begin
          r_buf   <= w_merge;
          r_state <= c_WR;
        end
        c_WR:    r_state <= c_RESP;
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == c_IDLE);
  assign resp_valid  = (r_state == c_RESP);
  assign resp_err    = resp_valid && r_err;
  assign resp_rdata  = resp_valid ? r_rdata : 32'h0;
  assign mem_enable  = (r_state == c_RD) || (r_state == c_RMW_RD) || (r_state == c_WR);
  assign mem_wr      = (r_state == c_WR);
  assign mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_data_in = r_buf;

endmodule
`default_nettype wire
